// File: rtl/bike_light_pkg.sv
// Shared types and constants for the bike-light timing blocks (timer, period meter, inputs).
package bike_light_pkg;

  // Tick counter width shared by the timer load value and the period meter.
  localparam int unsigned TICK_WIDTH              = 9;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } meter_state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Control/result bundle of the pulse period meter: tick and pulse inputs, period result outputs.
interface pulse_period_meter_if #(
    parameter int unsigned WIDTH = bike_light_pkg::TICK_WIDTH
);

    logic             count_en;
    logic             pulse_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             measuring;

    modport master (
        output count_en,
        output pulse_in,
        input  period,
        input  period_valid,
        input  timeout,
        input  measuring
    );

    modport slave (
        input  count_en,
        input  pulse_in,
        output period,
        output period_valid,
        output timeout,
        output measuring
    );

endinterface

// File: rtl/input_conditioner.sv
// Synchronizer, optional stability filter (PERIOD_METER_DEBOUNCE_EN) and rising-edge detector
// for an asynchronous level input.
module input_conditioner
    import bike_light_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   level;
    logic                   edge_q, edge_d;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PERIOD_METER_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           filt_q, filt_d;

    // Counts consecutive clocks where the synchronized level disagrees with the filtered one.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync_out != filt_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync_out;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_out;
`endif

    assign edge_d = level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign rise_o = level & ~edge_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures count_en ticks between successive rising edges of pulse_in; input filtering is
// enabled by PERIOD_METER_DEBOUNCE_EN inside the input conditioner.
module pulse_period_meter
    import bike_light_pkg::*;
#(
    parameter int unsigned WIDTH           = TICK_WIDTH,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    pulse_period_meter_if.slave  bus
);

    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             timeout_q, timeout_d;
    logic             rise;

    input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (bus.pulse_in),
        .rise_o (rise)
    );

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        timeout_d      = timeout_q;

        unique case (state_q)
            StIdle: begin
                // The first edge only opens an interval, so nothing is reported here.
                counter_d = '0;
                if (rise) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                // A rise takes priority over a coincident tick; that tick is dropped.
                if (rise) begin
                    period_d       = counter_q;
                    period_valid_d = 1'b1;
                    counter_d      = '0;
                    timeout_d      = 1'b0;
                end else if (bus.count_en) begin
                    if (counter_q == CntMax) begin
                        timeout_d = 1'b1;
                        counter_d = '0;
                        state_d   = StIdle;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            counter_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.measuring    = (state_q == StMeasure);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed and random pulse trains checked against an
// edge-history/prefix-sum reference of the interval rules.
module tb_pulse_period_meter;
    import bike_light_pkg::*;

    localparam int unsigned W    = TICK_WIDTH;
    localparam int unsigned S    = SYNC_STAGES_DEFAULT;
    localparam int          MAXV = (1 << W) - 1;
    localparam int          MAXE = 65535;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pulse_period_meter_if #(.WIDTH(W)) bus ();

    pulse_period_meter #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: pulse samples and running tick totals, indexed by clock edge since reset release.
    int samp   [0:MAXE];
    int ce_pre [0:MAXE];
    int e;
    bit armed;
    int last_rise;
    int exp_period;
    bit exp_valid;
    bit exp_to;

    int obs_valid_cnt;
    int obs_last_period;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int s_at(input int k);
        return (k >= 1) ? samp[k] : 0;
    endfunction

    task automatic model_reset();
        e          = 0;
        armed      = 1'b0;
        last_rise  = 0;
        exp_period = 0;
        exp_valid  = 1'b0;
        exp_to     = 1'b0;
        samp[0]    = 0;
        ce_pre[0]  = 0;
    endtask

    task automatic step(input bit ce, input bit pin);
        bit r;
        bus.count_en = ce;
        bus.pulse_in = pin;
        @(posedge clk);
        e++;
        samp[e]   = int'(pin);
        ce_pre[e] = ce_pre[e-1] + int'(ce);
        // The edge first sampled high is acted on S edges later.
        r = (s_at(e - S) == 1) && (s_at(e - S - 1) == 0);
        exp_valid = 1'b0;
        if (armed) begin
            if (r) begin
                exp_valid  = 1'b1;
                exp_period = ce_pre[e-1] - ce_pre[last_rise];
                exp_to     = 1'b0;
                last_rise  = e;
            end else if (ce && (ce_pre[e] - ce_pre[last_rise] == MAXV + 1)) begin
                exp_to = 1'b1;
                armed  = 1'b0;
            end
        end else if (r) begin
            armed     = 1'b1;
            last_rise = e;
        end
        #1;
        chk("period_valid", int'(bus.period_valid), int'(exp_valid));
        chk("period", int'(bus.period), exp_period);
        chk("timeout", int'(bus.timeout), int'(exp_to));
        chk("measuring", int'(bus.measuring), int'(armed));
        if (bus.period_valid) begin
            obs_valid_cnt++;
            obs_last_period = int'(bus.period);
        end
    endtask

    task automatic do_reset();
        bus.count_en = 1'b0;
        bus.pulse_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_period", int'(bus.period), 0);
        chk("rst_valid", int'(bus.period_valid), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        chk("rst_measuring", int'(bus.measuring), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_period", int'(bus.period), 0);
        chk("rst_hold_measuring", int'(bus.measuring), 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic gap(input int ticks, input int div);
        for (int t = 0; t < ticks; t++) begin
            repeat (div - 1) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    // Pulse held until its rise is acted on; ce_on_rise places a tick on that same edge.
    task automatic pulse(input bit ce_on_rise);
        repeat (S) step(1'b0, 1'b1);
        step(ce_on_rise, 1'b1);
    endtask

    initial begin
        int run;
        bit lvl;
        bus.count_en = 1'b0;
        bus.pulse_in = 1'b0;
        model_reset();
        do_reset();

        // Steady train, one tick every 6 clocks, 60-tick spacing.
        obs_valid_cnt = 0;
        pulse(1'b0);
        gap(60, 6);
        pulse(1'b0);
        gap(60, 6);
        pulse(1'b0);
        repeat (4) step(1'b0, 1'b0);
        chk("periodic_valids", obs_valid_cnt, 2);
        chk("periodic_period", obs_last_period, 60);
        chk("periodic_timeout", int'(bus.timeout), 0);

        // Tick on the rise edge is excluded and not carried into the next interval.
        obs_valid_cnt = 0;
        gap(5, 2);
        pulse(1'b1);
        gap(10, 2);
        pulse(1'b0);
        chk("coincident_valids", obs_valid_cnt, 2);
        chk("coincident_period", obs_last_period, 10);

        // Zero-length interval.
        obs_valid_cnt = 0;
        repeat (2) step(1'b0, 1'b0);
        pulse(1'b0);
        repeat (2) step(1'b0, 1'b0);
        pulse(1'b0);
        step(1'b0, 1'b0);
        chk("zero_valids", obs_valid_cnt, 2);
        chk("zero_period", obs_last_period, 0);

        // Full-scale count with rise on the saturating tick: reported, no timeout.
        gap(MAXV, 1);
        pulse(1'b1);
        chk("fullscale_period", obs_last_period, MAXV);
        chk("fullscale_timeout", int'(bus.timeout), 0);

        // Saturation without a rise.
        obs_valid_cnt = 0;
        gap(MAXV + 1, 1);
        chk("sat_timeout", int'(bus.timeout), 1);
        chk("sat_measuring", int'(bus.measuring), 0);
        chk("sat_period_kept", int'(bus.period), MAXV);
        chk("sat_no_valid", obs_valid_cnt, 0);
        pulse(1'b0);
        gap(20, 3);
        chk("sat_rearm_sticky", int'(bus.timeout), 1);
        pulse(1'b0);
        chk("sat_recover_period", obs_last_period, 20);
        chk("sat_recover_timeout", int'(bus.timeout), 0);

        // Reset mid-interval; the first edge after release only re-arms.
        gap(25, 2);
        do_reset();
        obs_valid_cnt = 0;
        pulse(1'b0);
        gap(7, 2);
        pulse(1'b0);
        step(1'b0, 1'b0);
        chk("post_reset_valids", obs_valid_cnt, 1);
        chk("post_reset_period", obs_last_period, 7);

        // Random intervals built from clean pulses.
        repeat (30) begin
            gap(int'($urandom_range(0, 30)), int'($urandom_range(1, 4)));
            pulse(1'($urandom_range(0, 1)));
        end

        // Fully random ticks and pulse levels, including single-clock pulses.
        run = 0;
        lvl = 1'b0;
        repeat (1500) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = int'($urandom_range(1, 6));
            end
            run--;
            step(($urandom_range(0, 3) == 0), lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
